instruction_cache: RTL and testbench

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

---
 rtl/instruction_cache_pkg.sv | 32 +++
 rtl/instruction_cache.sv | 134 +++++++++++++
 tb/tb_instruction_cache.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared fetch-port bundle types and instruction-cache defaults.
// Imported by the cache and by anything that talks to its fetch port.
package Bundle;

    localparam int DEFAULT_NUM_LINES      = 16;
    localparam int DEFAULT_WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } IcState;

    typedef struct packed {
        logic [31:0] addr;
    } MemoryReq;

    typedef struct packed {
        MemoryReq req;
        logic     req_valid;
    } MemoryIn;

    typedef struct packed {
        logic [31:0] data;
    } MemoryRes;

    typedef struct packed {
        MemoryRes res;
        logic     resp_valid;
    } MemoryOut;

endpackage

// File: rtl/instruction_cache.sv
// Direct-mapped, blocking instruction cache with a one-word-at-a-time line refill.
// Lookup is combinational; a miss stalls the fetch until the whole line is filled.
module instruction_cache
    import Bundle::*;
#(
    parameter int NUM_LINES      = DEFAULT_NUM_LINES,
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  MemoryIn     imem_in,
    output MemoryOut    imem_out,
    output logic        cmiss_stall,
    input  logic        invalidate,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int OFF_W    = $clog2(WORDS_PER_LINE);
    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int LINE_LSB = 2 + OFF_W;
    localparam int TAG_W    = 32 - LINE_LSB - IDX_W;

    IcState                state;
    logic [OFF_W-1:0]      counter;
    logic [31-LINE_LSB:0]  fill_line;
    logic                  pending_inv;
    logic [NUM_LINES-1:0]  valid;
    logic [TAG_W-1:0]      tag_arr  [NUM_LINES];
    logic [31:0]           data_arr [NUM_LINES][WORDS_PER_LINE];

    logic [OFF_W-1:0]      req_off;
    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit;
    logic                  miss;
    logic                  last_word;
    logic                  fill_done;
    logic                  unused_byte_bits;

    assign req_off          = imem_in.req.addr[2 +: OFF_W];
    assign req_idx          = imem_in.req.addr[LINE_LSB +: IDX_W];
    assign req_tag          = imem_in.req.addr[31 -: TAG_W];
    assign unused_byte_bits = ^imem_in.req.addr[1:0];

    // The refill works from the latched line address so a redirect mid-refill cannot corrupt it.
    assign fill_idx  = fill_line[0 +: IDX_W];
    assign fill_tag  = fill_line[IDX_W +: TAG_W];

    assign hit       = imem_in.req_valid && (state == IDLE) && valid[req_idx]
                       && (tag_arr[req_idx] == req_tag);
    assign miss      = imem_in.req_valid && (state == IDLE) && !hit;
    assign last_word = (counter == OFF_W'(WORDS_PER_LINE - 1));
    assign fill_done = (state == WAIT) && mem_resp_valid && last_word;

    always_comb begin
        imem_out            = '0;
        imem_out.resp_valid = hit;
        if (hit) begin
            imem_out.res.data = data_arr[req_idx][req_off];
        end
    end

    assign cmiss_stall   = miss || (state != IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = {fill_line, counter, 2'b00};

    // An invalidate seen mid-refill is held back and also wipes the line just filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            fill_line   <= '0;
            pending_inv <= 1'b0;
            valid       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (invalidate) begin
                        valid <= '0;
                    end
                    if (miss) begin
                        state     <= REQ;
                        counter   <= '0;
                        fill_line <= imem_in.req.addr[31:LINE_LSB];
                    end
                end
                REQ: begin
                    if (invalidate) begin
                        pending_inv <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (invalidate) begin
                        pending_inv <= 1'b1;
                    end
                    if (mem_resp_valid) begin
                        if (!last_word) begin
                            counter <= counter + 1'b1;
                            state   <= REQ;
                        end else begin
                            state       <= IDLE;
                            pending_inv <= 1'b0;
                            if (pending_inv || invalidate) begin
                                valid <= '0;
                            end else begin
                                valid[fill_idx] <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == WAIT) && mem_resp_valid) begin
            data_arr[fill_idx][counter] <= mem_resp_data;
        end
        if (fill_done) begin
            tag_arr[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed refill scenarios followed by random fetch traffic,
// checked against a line-level model of which lines the cache should currently hold.
module tb_instruction_cache;
    import Bundle::*;

    localparam int NL  = 16;
    localparam int WPL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    MemoryIn     imem_in;
    MemoryOut    imem_out;
    logic        cmiss_stall;
    logic        invalidate;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int checks = 0;
    int errors = 0;

    bit          m_valid [NL];
    int unsigned m_tag   [NL];

    logic [31:0] acc_q[$];
    bit          resp_pending;
    int          resp_delay;
    logic [31:0] resp_addr;
    bit          prev_held;
    logic [31:0] prev_addr;
    int          force_low;
    int          ready_pct;
    int          max_lat;
    int          sc;

    always #5 clk = ~clk;

    instruction_cache #(
        .NUM_LINES      (NL),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_in        (imem_in),
        .imem_out       (imem_out),
        .cmiss_stall    (cmiss_stall),
        .invalidate     (invalidate),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Backing memory contents: the 0x100 line holds 0x11..0x44, everything else a hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110) begin
            return 32'h11 * ((a - 32'h100) / 4 + 1);
        end
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clearModel();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endtask

    // Backing-memory responder, called once per cycle just after the falling edge.
    task automatic memStep();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (resp_pending) begin
            if (resp_delay == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_word(resp_addr);
                resp_pending   = 1'b0;
            end else begin
                resp_delay--;
            end
        end
        if (mem_req_valid) begin
            checkOutput("single_outstanding", 32'(resp_pending), 0);
            if (prev_held) checkOutput("held_req_addr", mem_req_addr, prev_addr);
            if (force_low > 0) begin
                mem_req_ready = 1'b0;
                force_low--;
            end else begin
                mem_req_ready = ($urandom_range(99) < ready_pct);
            end
            if (mem_req_ready) begin
                acc_q.push_back(mem_req_addr);
                resp_pending = 1'b1;
                resp_delay   = int'($urandom_range(max_lat));
                resp_addr    = mem_req_addr;
            end
            prev_held = !mem_req_ready;
            prev_addr = mem_req_addr;
        end else begin
            if (prev_held) checkOutput("held_req_valid", 32'(mem_req_valid), 1);
            prev_held     = 1'b0;
            mem_req_ready = 1'($urandom_range(1));
        end
    endtask

    task automatic idleCycle(input bit inv);
        imem_in.req_valid = 1'b0;
        invalidate        = inv;
        #1;
        checkOutput("idle_stall", 32'(cmiss_stall), 0);
        checkOutput("idle_resp_valid", 32'(imem_out.resp_valid), 0);
        checkOutput("idle_mem_req", 32'(mem_req_valid), 0);
        memStep();
        @(negedge clk);
        invalidate = 1'b0;
        if (inv) clearModel();
    endtask

    // One fetch, run to completion. inv_word/abort_word >= 0 pulse invalidate or reset
    // during the WAIT of that word of the first refill.
    task automatic applyStimulus(input logic [31:0] addr, input int inv_word,
                                 input int abort_word, output int stall_cycles);
        int unsigned idx, tag_v;
        int          cycles, refills;
        bit          exp_hit, done, inv_done, aborted;
        logic [31:0] base, exp_data;
        idx      = (addr / 16) % NL;
        tag_v    = addr / 256;
        base     = addr - (addr % 16);
        exp_data = mem_word(addr - (addr % 4));
        exp_hit  = m_valid[idx] && (m_tag[idx] == tag_v);
        imem_in.req.addr  = addr;
        imem_in.req_valid = 1'b1;
        acc_q.delete();
        stall_cycles = 0;
        #1;
        checkOutput("lookup_stall", 32'(cmiss_stall), 32'(!exp_hit));
        checkOutput("lookup_resp_valid", 32'(imem_out.resp_valid), 32'(exp_hit));
        if (exp_hit) begin
            checkOutput("hit_data", imem_out.res.data, exp_data);
            checkOutput("hit_no_mem_req", 32'(mem_req_valid), 0);
            memStep();
            imem_in.req_valid = 1'b0;
            @(negedge clk);
            return;
        end
        checkOutput("miss_bubble", imem_out.res.data, 0);
        memStep();
        @(negedge clk);
        done = 0; aborted = 0; inv_done = 0; cycles = 0;
        while (cycles < 400) begin
            invalidate = 1'b0;
            cycles++;
            #1;
            if (imem_out.resp_valid) begin
                done = 1;
                checkOutput("fill_data", imem_out.res.data, exp_data);
                checkOutput("fill_stall_released", 32'(cmiss_stall), 0);
                memStep();
                break;
            end
            stall_cycles++;
            checkOutput("refill_stall", 32'(cmiss_stall), 1);
            memStep();
            if (inv_word >= 0 && !inv_done && acc_q.size() == inv_word + 1 && !mem_req_valid) begin
                invalidate = 1'b1;
                inv_done   = 1;
            end
            if (abort_word >= 0 && acc_q.size() == abort_word + 1 && !mem_req_valid) begin
                rst_n   = 1'b0;
                aborted = 1;
                break;
            end
            @(negedge clk);
        end
        if (aborted) return;
        if (!done) checkOutput("fetch_timeout", 0, 1);
        refills = (inv_word >= 0) ? 2 : 1;
        checkOutput("mem_req_count", acc_q.size(), WPL * refills);
        for (int i = 0; i < acc_q.size() && i < WPL * refills; i++) begin
            checkOutput("mem_req_addr", acc_q[i], base + 4 * (i % WPL));
        end
        if (inv_word >= 0) clearModel();
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag_v;
        imem_in.req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_in        = '0;
        invalidate     = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        resp_pending   = 0;
        resp_delay     = 0;
        resp_addr      = '0;
        prev_held      = 0;
        prev_addr      = '0;
        force_low      = 0;
        ready_pct      = 100;
        max_lat        = 0;
        clearModel();
        foreach (m_tag[i]) m_tag[i] = 0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_stall", 32'(cmiss_stall), 0);
        checkOutput("reset_resp_valid", 32'(imem_out.resp_valid), 0);
        checkOutput("reset_mem_req", 32'(mem_req_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] cold miss and hit");
        applyStimulus(32'h100, -1, -1, sc);
        checkOutput("cold_stall_cycles", sc, 2 * WPL);
        applyStimulus(32'h108, -1, -1, sc);

        $display("[TB] invalidate alongside a hit");
        imem_in.req.addr  = 32'h104;
        imem_in.req_valid = 1'b1;
        invalidate        = 1'b1;
        #1;
        checkOutput("inv_cycle_hit", 32'(imem_out.resp_valid), 1);
        checkOutput("inv_cycle_data", imem_out.res.data, 32'h22);
        memStep();
        @(negedge clk);
        invalidate        = 1'b0;
        imem_in.req_valid = 1'b0;
        clearModel();
        applyStimulus(32'h104, -1, -1, sc);

        $display("[TB] conflict eviction");
        applyStimulus(32'h200, -1, -1, sc);
        applyStimulus(32'h100, -1, -1, sc);

        $display("[TB] ready held low");
        force_low = 3;
        applyStimulus(32'h340, -1, -1, sc);
        checkOutput("ready_low_stall_cycles", sc, 2 * WPL + 3);

        $display("[TB] invalidate during refill");
        idleCycle(1);
        applyStimulus(32'h100, 1, -1, sc);
        checkOutput("inv_refill_stall_cycles", sc, 4 * WPL + 1);

        $display("[TB] reset during refill");
        idleCycle(1);
        applyStimulus(32'h100, -1, 2, sc);
        imem_in.req_valid = 1'b0;
        invalidate        = 1'b0;
        mem_resp_valid    = 1'b0;
        resp_pending      = 0;
        prev_held         = 0;
        #1;
        checkOutput("midreset_stall", 32'(cmiss_stall), 0);
        checkOutput("midreset_mem_req", 32'(mem_req_valid), 0);
        @(negedge clk);
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        #1;
        checkOutput("stray_resp_stall", 32'(cmiss_stall), 0);
        checkOutput("stray_resp_mem_req", 32'(mem_req_valid), 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        clearModel();
        applyStimulus(32'h100, -1, -1, sc);
        applyStimulus(32'h10C, -1, -1, sc);

        $display("[TB] random traffic");
        for (int n = 0; n < 150; n++) begin
            int unsigned r;
            logic [31:0] a;
            ready_pct = 30 + int'($urandom_range(70));
            max_lat   = int'($urandom_range(2));
            r = $urandom_range(9);
            a = ($urandom_range(3) << 8) | ($urandom_range(15) << 4)
                | ($urandom_range(3) << 2) | $urandom_range(3);
            if (r == 0)      idleCycle(0);
            else if (r == 1) idleCycle(1);
            else             applyStimulus(a, -1, -1, sc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
